control_miscare_param: RTL
==========================

Name: control_miscare_param

Overview:
Clocked, parametrised line-follower motion controller for N reflective sensors. It drives the two motor drivers (direction plus PWM compare value), counts laps on debounced finish-line crossings and stops on a per-circuit lap target. It also searches for a lost line toward the last remembered side and gives up after a timeout. It sits between the sensor input pins and the PWM comparators / driver pins.

Parameters:
N_SENZ, 5, number of sensors; odd and >=3. C=(N_SENZ-1)/2 is the centre index. Index 0 and N_SENZ-1 are the marker sensors; 1..N_SENZ-2 are track sensors.
DC_W, 12, width of the PWM compare values.
DC_MAX, 12'h999, straight-ahead duty value.
DC_PAS, 12'h200, duty reduction per step of track error.
DC_PIVOT, 12'h600, duty used for pivot and search.
LAP_W, 8, lap counter width.
TURE_C2, 10, lap target for circuit 2'b10.
DEB_CICLURI, 16, debounce length in cycles for marker sensors.
TIMEOUT_CAUTARE, 50000, maximum number of search cycles.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset.
en  in  1  run enable.
senzori  in  N_SENZ  sensor inputs, 1 = black; index <C is the right side.
circuit  in  2  00 idle/clear, 01 one lap, 10 TURE_C2 laps, 11 endurance.
directie_driverA  out  2  right-motor direction: 10 forward, 01 reverse, 00 brake.
directie_driverB  out  2  left-motor direction, same encoding.
factor_dc_driverA  out  DC_W  PWM compare value for driver A.
factor_dc_driverB  out  DC_W  PWM compare value for driver B.
semnal_dreapta  out  1  right indicator.
semnal_stanga  out  1  left indicator.
stop  out  1  brake light.
count_ture  out  LAP_W  completed laps.
terminat  out  1  lap target reached.
stare  out  3  FSM state code.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: directions 00, duties 0, indicators 0, stop 1, count_ture 0, terminat 0, state IDLE, side memory NONE.
- senzori pass through a 2-flop synchronizer. All outputs are registered. Latency from a sensor change to an output change is 3 cycles.
- FSM states: IDLE=0, URMARIRE=1, CAUTARE=2, OPRIT=3, PIERDUT=4.
- Any state with circuit==00: go to IDLE and clear count_ture and terminat.
- Any state with en==0: go to IDLE; count_ture is held.
- IDLE -> URMARIRE when en=1 and circuit!=00. In IDLE: directions 00, duties 0.
- URMARIRE steering, using only the track sensors:
  - d = C minus the highest active right-side index; symmetric rule on the left side.
  - Only one side active, d<C-1: that side's motor forward with duty DC_MAX-d*DC_PAS, saturating at 0; other motor at DC_MAX.
  - Only one side active, d==C-1 (outermost track sensor): pivot. That side's motor reverses (01) at DC_PIVOT; the other motor goes forward at DC_PIVOT.
  - Right side active sets memory to DREAPTA (drives motor A); left side sets STANGA (drives motor B).
  - Both sides active, or only the centre active: both motors forward at DC_MAX; memory unchanged.
- URMARIRE -> CAUTARE when no track sensor is active. The search timer clears on entry.
- CAUTARE:
  - Pivot toward the memory side at DC_PIVOT; if memory is NONE, both motors forward at DC_PIVOT.
  - Any track sensor active -> URMARIRE on the next cycle; memory is kept.
  - Timer reaching TIMEOUT_CAUTARE-1 -> PIERDUT.
- PIERDUT: directions 00, duties 0. Exit only via en=0 or circuit=00.
- Finish detection, active in URMARIRE and CAUTARE:
  - Both markers high for DEB_CICLURI consecutive cycles increments count_ture exactly once, saturating at all-ones.
  - The detector re-arms only after both markers have been low for DEB_CICLURI consecutive cycles.
  - Steering continues unchanged during the crossing.
- Lap target: 1 for circuit 01, TURE_C2 for circuit 10, none for circuit 11.
  - The cycle after count_ture reaches the target: OPRIT, terminat=1, directions 00, duties 0.
  - If circuit changes mid-run to a target already <= count_ture, go to OPRIT on the next cycle.
- OPRIT: hold until en=0 or circuit=00.
- Indicators: semnal_dreapta = synchronized marker 0; semnal_stanga = synchronized marker N_SENZ-1. Both high together acts as hazard; it is not masked.
- stop = 1 unless state is URMARIRE and the centre sensor is high.
- stare = the current state code.

Test Plan:
1. Bench settings: N_SENZ=5, DEB_CICLURI=4, TIMEOUT_CAUTARE=20. Reset, en=1, circuit=11, senzori=00100 -> after 3 cycles both directions 10, duties 12'h999, stop=0, stare=1.
2. senzori=00010 (index 1, right, d=1=C-1) -> directie_driverA=01, B=10, both duties 12'h600. Then senzori=00000 -> stare=2, A stays reversed. After 20 cycles -> stare=4, directions 00, stop=1.
3. circuit=01, markers 10001 for 3 cycles then low -> count_ture stays 0. Markers held for 4 cycles -> count_ture=1, then stare=3, terminat=1, duties 0.
4. circuit=10, ten debounced crossings separated by 4+ low cycles -> count_ture=10, OPRIT. Markers held 100 cycles -> a single increment only.
5. circuit switched to 00 mid-run with count_ture=5 -> stare=0, count_ture=0. Assert rst_n low mid-pivot -> all outputs at reset values asynchronously.
6. senzori=01010 (both sides active) -> both directions 10 at 12'h999; memory unchanged, confirmed by the subsequent search direction.

Source files
------------

// File: rtl/control_miscare_param.sv
// rtl/control_miscare_param.sv - line-follower motion controller: steering, lost-line search, lap counting
module control_miscare_param #(
    parameter int              N_SENZ          = 5,
    parameter int              DC_W            = 12,
    parameter logic [DC_W-1:0] DC_MAX          = 12'h999,
    parameter logic [DC_W-1:0] DC_PAS          = 12'h200,
    parameter logic [DC_W-1:0] DC_PIVOT        = 12'h600,
    parameter int              LAP_W           = 8,
    parameter int              TURE_C2         = 10,
    parameter int              DEB_CICLURI     = 16,
    parameter int              TIMEOUT_CAUTARE = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_SENZ-1:0] senzori,
    input  logic [1:0]        circuit,
    output logic [1:0]        directie_driverA,
    output logic [1:0]        directie_driverB,
    output logic [DC_W-1:0]   factor_dc_driverA,
    output logic [DC_W-1:0]   factor_dc_driverB,
    output logic              semnal_dreapta,
    output logic              semnal_stanga,
    output logic              stop,
    output logic [LAP_W-1:0]  count_ture,
    output logic              terminat,
    output logic [2:0]        stare
);
    localparam int C  = (N_SENZ - 1) / 2;
    localparam int TW = $clog2(TIMEOUT_CAUTARE + 1);
    localparam int DW = $clog2(DEB_CICLURI + 1);

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        URMARIRE = 3'd1,
        CAUTARE  = 3'd2,
        OPRIT    = 3'd3,
        PIERDUT  = 3'd4
    } stare_t;

    typedef enum logic [1:0] {
        MEM_NONE    = 2'd0,
        MEM_DREAPTA = 2'd1,
        MEM_STANGA  = 2'd2
    } mem_t;

    logic [N_SENZ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    stare_t            state_q, state_d;
    mem_t              mem_q, mem_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DW-1:0]     deb_q, deb_d;
    logic              armat_q, armat_d;
    logic [LAP_W-1:0]  count_q, count_d;
    logic              terminat_q, terminat_d;
    logic [1:0]        dir_a_q, dir_a_d, dir_b_q, dir_b_d;
    logic [DC_W-1:0]   dc_a_q, dc_a_d, dc_b_q, dc_b_d;
    logic              sd_q, sd_d, ss_q, ss_d, stop_q, stop_d;

    function automatic logic [DC_W-1:0] duty_pas(input int d);
        int p;
        p = d * int'(DC_PAS);
        if (p >= int'(DC_MAX)) return '0;
        return DC_W'(int'(DC_MAX) - p);
    endfunction

    always_comb begin
        logic             any_track, mk_r, mk_l, has_tgt;
        logic [LAP_W-1:0] tgt;
        int               r, l;

        sync1_d    = senzori;
        sync2_d    = sync1_q;
        state_d    = state_q;
        mem_d      = mem_q;
        timer_d    = timer_q;
        deb_d      = deb_q;
        armat_d    = armat_q;
        count_d    = count_q;
        terminat_d = terminat_q;
        dir_a_d    = 2'b00;
        dir_b_d    = 2'b00;
        dc_a_d     = '0;
        dc_b_d     = '0;

        any_track = |sync2_q[N_SENZ-2:1];
        mk_r      = sync2_q[0];
        mk_l      = sync2_q[N_SENZ-1];

        has_tgt = 1'b0;
        tgt     = '0;
        case (circuit)
            2'b01: begin has_tgt = 1'b1; tgt = LAP_W'(1);       end
            2'b10: begin has_tgt = 1'b1; tgt = LAP_W'(TURE_C2); end
            default: ;
        endcase

        // Finish line: count once per debounced crossing, re-arm only after a debounced clear
        if (state_q == URMARIRE || state_q == CAUTARE) begin
            if (armat_q) begin
                if (mk_r && mk_l) begin
                    if (deb_q == DW'(DEB_CICLURI - 1)) begin
                        deb_d   = '0;
                        armat_d = 1'b0;
                        if (count_q != '1) count_d = count_q + 1'b1;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d = '0;
                end
            end else begin
                if (!mk_r && !mk_l) begin
                    if (deb_q == DW'(DEB_CICLURI - 1)) begin
                        deb_d   = '0;
                        armat_d = 1'b1;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d = '0;
                end
            end
        end else if (state_q == IDLE) begin
            deb_d   = '0;
            armat_d = 1'b1;
        end

        case (state_q)
            IDLE: if (en && circuit != 2'b00) state_d = URMARIRE;
            URMARIRE: begin
                if (has_tgt && count_q >= tgt) begin
                    state_d = OPRIT;
                end else if (!any_track) begin
                    state_d = CAUTARE;
                    timer_d = '0;
                end
            end
            CAUTARE: begin
                if (has_tgt && count_q >= tgt)                state_d = OPRIT;
                else if (any_track)                           state_d = URMARIRE;
                else if (timer_q == TW'(TIMEOUT_CAUTARE - 1)) state_d = PIERDUT;
                else                                          timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase

        if (!en) state_d = IDLE;
        if (circuit == 2'b00) begin
            state_d    = IDLE;
            count_d    = '0;
            terminat_d = 1'b0;
        end
        if (state_d == OPRIT) terminat_d = 1'b1;

        // Motor outputs follow the state being entered so they line up with stare
        r = 0;
        l = 0;
        for (int i = 1; i < C; i++) if (sync2_q[i]) r = i;
        for (int i = N_SENZ - 2; i > C; i--) if (sync2_q[i]) l = i;

        if (state_d == URMARIRE) begin
            dir_a_d = DIR_FWD;
            dir_b_d = DIR_FWD;
            dc_a_d  = DC_MAX;
            dc_b_d  = DC_MAX;
            if (r != 0 && l == 0) begin
                mem_d = MEM_DREAPTA;
                if (C - r == C - 1) begin
                    dir_a_d = DIR_REV;
                    dc_a_d  = DC_PIVOT;
                    dc_b_d  = DC_PIVOT;
                end else begin
                    dc_a_d = duty_pas(C - r);
                end
            end else if (l != 0 && r == 0) begin
                mem_d = MEM_STANGA;
                if (l - C == C - 1) begin
                    dir_b_d = DIR_REV;
                    dc_a_d  = DC_PIVOT;
                    dc_b_d  = DC_PIVOT;
                end else begin
                    dc_b_d = duty_pas(l - C);
                end
            end
        end else if (state_d == CAUTARE) begin
            dir_a_d = (mem_q == MEM_DREAPTA) ? DIR_REV : DIR_FWD;
            dir_b_d = (mem_q == MEM_STANGA)  ? DIR_REV : DIR_FWD;
            dc_a_d  = DC_PIVOT;
            dc_b_d  = DC_PIVOT;
        end

        sd_d   = mk_r;
        ss_d   = mk_l;
        stop_d = !(state_d == URMARIRE && sync2_q[C]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= IDLE;
            mem_q      <= MEM_NONE;
            timer_q    <= '0;
            deb_q      <= '0;
            armat_q    <= 1'b1;
            count_q    <= '0;
            terminat_q <= 1'b0;
            dir_a_q    <= 2'b00;
            dir_b_q    <= 2'b00;
            dc_a_q     <= '0;
            dc_b_q     <= '0;
            sd_q       <= 1'b0;
            ss_q       <= 1'b0;
            stop_q     <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            mem_q      <= mem_d;
            timer_q    <= timer_d;
            deb_q      <= deb_d;
            armat_q    <= armat_d;
            count_q    <= count_d;
            terminat_q <= terminat_d;
            dir_a_q    <= dir_a_d;
            dir_b_q    <= dir_b_d;
            dc_a_q     <= dc_a_d;
            dc_b_q     <= dc_b_d;
            sd_q       <= sd_d;
            ss_q       <= ss_d;
            stop_q     <= stop_d;
        end
    end

    assign directie_driverA  = dir_a_q;
    assign directie_driverB  = dir_b_q;
    assign factor_dc_driverA = dc_a_q;
    assign factor_dc_driverB = dc_b_q;
    assign semnal_dreapta    = sd_q;
    assign semnal_stanga     = ss_q;
    assign stop              = stop_q;
    assign count_ture        = count_q;
    assign terminat          = terminat_q;
    assign stare             = state_q;
endmodule
